fp_divsqrt_iter: RTL

- Parametrised iterative mantissa engine for FDIV/FSQRT. Restoring radix-2, one quotient/root bit per cycle.
- Sits inside the FP divide path, between operand unpack/special-case handling and rounding.
- Output feeds the `mant`/`grs` fields of the rounding-stage input.
- Width is generic (single, double or test widths), and it adds valid/ready handshakes, a tag pass-through and a flush.

---
 rtl/fp_divsqrt_iter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fp_divsqrt_iter.sv
// Iterative restoring radix-2 mantissa engine for FDIV/FSQRT.
// Produces one quotient/root bit per cycle, plus guard/round bits and a sticky flag.
module fp_divsqrt_iter #(
    parameter int unsigned MANT_W = 53,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [MANT_W:0]   in_a,
    input  logic [MANT_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W+1:0] out_q,
    output logic              out_sticky,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned N  = MANT_W + 2;
    localparam int unsigned RW = N + 2;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] CntInit = CW'(N);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic                op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [MANT_W-1:0]   b_q, b_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [N-1:0]        q_q, q_d;
    logic [2*N-1:0]      rad_q, rad_d;

    logic [RW-1:0] div_b, div_diff, sq_rem, sq_t, sq_diff;
    logic          div_ge, sq_ge;

    // Division datapath: compare and subtract the divisor from the partial remainder.
    assign div_b    = {{(RW-MANT_W){1'b0}}, b_q};
    assign div_diff = rem_q - div_b;
    assign div_ge   = (rem_q >= div_b);

    // Square-root datapath: bring down the next radicand pair, trial value is 4*root+1.
    assign sq_rem  = {rem_q[N-1:0], rad_q[2*N-1 -: 2]};
    assign sq_t    = {q_q, 2'b01};
    assign sq_diff = sq_rem - sq_t;
    assign sq_ge   = (sq_rem >= sq_t);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        rad_d   = rad_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = in_op;
                    tag_d   = in_tag;
                    b_d     = in_b;
                    cnt_d   = CntInit;
                    q_d     = '0;
                    state_d = StRun;
                    if (in_op) begin
                        rem_d = '0;
                        rad_d = {in_a, {(MANT_W+3){1'b0}}};
                    end else begin
                        rem_d = {3'b000, in_a};
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntOne;
                if (op_q) begin
                    rad_d = {rad_q[2*N-3:0], 2'b00};
                    rem_d = sq_ge ? sq_diff : sq_rem;
                    q_d   = {q_q[N-2:0], sq_ge};
                end else begin
                    rem_d = div_ge ? {div_diff[RW-2:0], 1'b0} : {rem_q[RW-2:0], 1'b0};
                    q_d   = {q_q[N-2:0], div_ge};
                end
                if (cnt_q == CntOne) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Flush wins over both the accept and the result handshake.
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= 1'b0;
            tag_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            rad_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            rad_q   <= rad_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign out_q      = q_q;
    assign out_sticky = |rem_q;
    assign out_tag    = tag_q;

endmodule
